// File: rtl/ratio_sin_scaler.sv
// ratio_sin_scaler: y = +/- sat(round(a/(a+b+c) * sin_mag)), iterative divider.
// Half-up rounding is built when RATIO_SIN_SCALER_ROUND_EN is defined.
module ratio_sin_scaler #(
  parameter int W    = 12,
  parameter int FRAC = 14,
  parameter int S    = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [S-1:0]  sin_mag,
  input  logic          sin_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FRAC:0] y,
  output logic          div_zero
);

  localparam int DW = W + 2;
  localparam int RW = W + 3;
  localparam int QW = FRAC + 1;
  localparam int PW = QW + S;
  localparam int CW = $clog2(QW);

  localparam logic [S-1:0]  SIN_ONE = {1'b1, {(S-1){1'b0}}};
  localparam logic [PW-1:0] POS_MAX = PW'((1 << FRAC) - 1);
  localparam logic [PW-1:0] NEG_MAX = PW'(1 << FRAC);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    MUL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  a_q, b_q, c_q;
  logic [S-1:0]  sin_q;
  logic          sign_q;
  logic [RW-1:0] rem;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;
  logic [QW-1:0] y_q;
  logic          dz_q;

  logic [DW-1:0] div_sum;
  logic          ge;
  logic [RW-1:0] rem_nx;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_r;
  logic [PW-1:0] mag_full;
  logic [QW-1:0] mag;
  logic [QW-1:0] y_nx;

  assign div_sum = DW'(a_q) + DW'(b_q) + DW'(c_q);

  // Remainder stays below 2*divisor, so one compare yields one quotient bit.
  assign ge     = rem >= {1'b0, div_sum};
  assign rem_nx = (ge ? rem - {1'b0, div_sum} : rem) << 1;

  assign prod = PW'(q) * PW'(sin_q);

`ifdef RATIO_SIN_SCALER_ROUND_EN
  assign prod_r = prod + (PW'(1) << (S - 2));
`else
  assign prod_r = prod;
`endif

  assign mag_full = prod_r >> (S - 1);

  always_comb begin
    mag = mag_full[QW-1:0];
    if (sign_q) begin
      if (mag_full > NEG_MAX) mag = NEG_MAX[QW-1:0];
    end else begin
      if (mag_full > POS_MAX) mag = POS_MAX[QW-1:0];
    end
    y_nx = sign_q ? (QW'(0) - mag) : mag;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = DIV;
      DIV:  if (cnt == '0) state_nx = MUL;
      MUL:  state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      sin_q  <= '0;
      sign_q <= 1'b0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      y_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            c_q    <= c;
            sin_q  <= (sin_mag > SIN_ONE) ? SIN_ONE : sin_mag;
            sign_q <= sin_sign;
            rem    <= RW'(a);
            q      <= '0;
            cnt    <= CW'(FRAC);
          end
        end
        DIV: begin
          rem <= rem_nx;
          q   <= {q[QW-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        MUL: begin
          y_q  <= (div_sum == '0) ? '0 : y_nx;
          dz_q <= (div_sum == '0);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign y         = y_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_ratio_sin_scaler.sv
// tb_ratio_sin_scaler: directed vectors with hand-computed results.
// Latency counts the accept edge as cycle 1.
module tb_ratio_sin_scaler;

  localparam int W    = 12;
  localparam int FRAC = 14;
  localparam int S    = 13;
  localparam int LAT  = FRAC + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W-1:0]  c = '0;
  logic [S-1:0]  sin_mag = '0;
  logic          sin_sign = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FRAC:0] y;
  logic          div_zero;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ratio_sin_scaler #(
    .W(W),
    .FRAC(FRAC),
    .S(S)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .c(c),
    .sin_mag(sin_mag),
    .sin_sign(sin_sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .div_zero(div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] tc, input logic [S-1:0] tm,
                        input logic ts, input logic [FRAC:0] ey,
                        input logic edz, input string tag,
                        input int hold);
    int lat;
    int k;
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb;
    c = tc;
    sin_mag = tm;
    sin_sign = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LAT + 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(LAT));
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".dz"}, 32'(div_zero), 32'(edz));
    if (hold > 0) begin
      a = 12'd7;
      b = 12'd9;
      c = 12'd3;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({tag, ".hold_y"}, 32'(y), 32'(ey));
        check({tag, ".hold_ov"}, 32'(out_valid), 32'd1);
        check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #12;
    check("rst.rdy", 32'(in_ready), 32'd1);
    check("rst.ov", 32'(out_valid), 32'd0);
    check("rst.y", 32'(y), 32'd0);
    check("rst.dz", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(12'd100, 12'd100, 12'd200, 13'd4096, 1'b0, 15'd4096, 1'b0,
           "quarter", 0);
    run_op(12'd4095, 12'd0, 12'd0, 13'd4096, 1'b0, 15'h3fff, 1'b0,
           "sat_pos", 0);
    run_op(12'd4095, 12'd0, 12'd0, 13'd4096, 1'b1, 15'h4000, 1'b0,
           "sat_neg", 0);
    run_op(12'd0, 12'd0, 12'd0, 13'd4096, 1'b0, 15'd0, 1'b1,
           "div0", 0);
`ifdef RATIO_SIN_SCALER_ROUND_EN
    run_op(12'd1, 12'd2, 12'd0, 13'd2048, 1'b0, 15'd2731, 1'b0,
           "third", 0);
`else
    run_op(12'd1, 12'd2, 12'd0, 13'd2048, 1'b0, 15'd2730, 1'b0,
           "third", 0);
`endif
    run_op(12'd100, 12'd100, 12'd200, 13'd2048, 1'b1, 15'h7800, 1'b0,
           "neg_half", 0);
    run_op(12'd100, 12'd100, 12'd200, 13'd8191, 1'b0, 15'd4096, 1'b0,
           "sin_clamp", 0);
    run_op(12'd100, 12'd100, 12'd200, 13'd4096, 1'b0, 15'd4096, 1'b0,
           "stall", 5);
    run_op(12'd1, 12'd1, 12'd0, 13'd4096, 1'b0, 15'd8192, 1'b0,
           "after_stall", 0);

    @(negedge clk);
    a = 12'd3;
    b = 12'd1;
    c = 12'd0;
    sin_mag = 13'd4096;
    sin_sign = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.ov", 32'(out_valid), 32'd0);
    check("midrst.y", 32'(y), 32'd0);
    check("midrst.rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(12'd100, 12'd100, 12'd200, 13'd4096, 1'b0, 15'd4096, 1'b0,
           "post_rst", 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
